// File: rtl/opcode_display_pkg.sv
// Shared definitions for the opcode label display: label width, the opcode
// to mnemonic-label table, active-low seven-segment patterns and the BCD
// converter state encoding.
package opcode_display_pkg;

  localparam int LABEL_W = 8;

  typedef struct packed {
    logic               valid;
    logic [LABEL_W-1:0] label;
  } label_entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_CONV
  } conv_state_t;

  // Segments a..g on bits 0..6, active-low.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Opcodes 0..7 -> labels 1..8, opcode 9 -> 9, opcode 14 -> 10; all else invalid.
  function automatic label_entry_t label_lookup(input logic [31:0] opcode);
    label_entry_t e;
    e.valid = 1'b0;
    e.label = '0;
    if (opcode < 32'd8) begin
      e.valid = 1'b1;
      e.label = LABEL_W'(opcode) + LABEL_W'(1);
    end else if (opcode == 32'd9) begin
      e.valid = 1'b1;
      e.label = LABEL_W'(9);
    end else if (opcode == 32'd14) begin
      e.valid = 1'b1;
      e.label = LABEL_W'(10);
    end
    return e;
  endfunction

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/opcode_bcd_converter.sv
// Shift-add-3 (double dabble) binary-to-BCD converter. A start in IDLE loads
// the label and runs LABEL_W shift cycles; done pulses for one cycle after the
// last shift while bcd_o holds the result. overflow_o flags a label that needs
// more than DIGITS decimal digits.
module opcode_bcd_converter
  import opcode_display_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [LABEL_W-1:0]    label_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  overflow_o
);

  // An 8-bit label needs three BCD digits; keep at least that many internally.
  localparam int NIB   = (DIGITS > 3) ? DIGITS : 3;
  localparam int CNT_W = $clog2(LABEL_W + 1);

  conv_state_t        state;
  logic [CNT_W-1:0]   count;
  logic [LABEL_W-1:0] label_q;
  logic [4*NIB-1:0]   bcd_q;
  logic [4*NIB-1:0]   bcd_shift;
  logic [3:0]         nib;
  logic               carry;

  // Adjust every nibble >= 5 by +3, then shift {bcd, label} left by one.
  // NOTE: every variable gets a value before any branch, so no latch is inferred.
  always_comb begin
    nib       = '0;
    carry     = label_q[LABEL_W-1];
    bcd_shift = '0;
    for (int i = 0; i < NIB; i++) begin
      nib = bcd_q[4*i +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      bcd_shift[4*i +: 4] = {nib[2:0], carry};
      carry = nib[3];
    end
  end

  // Conversion FSM with registered busy/done handshake.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      count   <= '0;
      label_q <= '0;
      bcd_q   <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state   <= ST_CONV;
            count   <= CNT_W'(LABEL_W);
            label_q <= label_i;
            bcd_q   <= '0;
            busy_o  <= 1'b1;
          end
        end
        ST_CONV: begin
          bcd_q   <= bcd_shift;
          label_q <= {label_q[LABEL_W-2:0], 1'b0};
          count   <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bcd_o = bcd_q[4*DIGITS-1:0];

  generate
    if (NIB > DIGITS) begin : g_ovf
      assign overflow_o = |bcd_q[4*NIB-1:4*DIGITS];
    end else begin : g_no_ovf
      assign overflow_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/opcode_display_scanner.sv
// Opcode label display driver: captures an opcode on load, converts its label
// to BCD, commits digits and valid flag atomically, and time-multiplexes
// DIGITS digits onto one active-low segment bus.
// Optional feature macro: OPCODE_DISPLAY_BLINK_EN (invalid display blinks).
module opcode_display_scanner
  import opcode_display_pkg::*;
#(
  parameter int OPCODE_W   = 4,
  parameter int DIGITS     = 2,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_LOG2 = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                load_i,
  output logic                busy_o,
  output logic [6:0]          seg_o,
  output logic [DIGITS-1:0]   digit_sel_o
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);

  label_entry_t        entry;
  logic                load_ok;
  logic                conv_done;
  logic                conv_ovf;
  logic [4*DIGITS-1:0] conv_bcd;
  logic                valid_q;
  logic [4*DIGITS-1:0] disp_bcd;
  logic                disp_valid;
  logic [PRE_W-1:0]    presc;
  logic [IDX_W-1:0]    idx;
  logic                slot_wrap;
  logic [IDX_W-1:0]    idx_next;
  logic [4*DIGITS-1:0] bcd_next;
  logic                valid_next;
  logic [3:0]          digit_next;
  logic                blank_now;

  assign entry     = label_lookup(32'(opcode_i));
  assign load_ok   = load_i & ~busy_o;
  assign slot_wrap = (presc == PRE_W'(SCAN_DIV - 1));

  opcode_bcd_converter #(.DIGITS(DIGITS)) u_conv (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (load_i),
    .label_i    (entry.label),
    .busy_o     (busy_o),
    .done_o     (conv_done),
    .bcd_o      (conv_bcd),
    .overflow_o (conv_ovf)
  );

  // Post-edge scan index and display contents, so the registered outputs
  // reflect a wrap or a commit on the same edge it happens.
  always_comb begin
    idx_next = idx;
    if (slot_wrap) idx_next = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    bcd_next   = disp_bcd;
    valid_next = disp_valid;
    if (conv_done) begin
      bcd_next   = conv_bcd;
      valid_next = valid_q & ~conv_ovf;
    end
    digit_next = bcd_next[3:0];
    for (int i = 0; i < DIGITS; i++)
      if (idx_next == IDX_W'(i)) digit_next = bcd_next[4*i +: 4];
  end

`ifdef OPCODE_DISPLAY_BLINK_EN
  logic [BLINK_LOG2:0] blink_cnt;
  logic [BLINK_LOG2:0] blink_next;

  assign blink_next = slot_wrap ? blink_cnt + 1'b1 : blink_cnt;
  assign blank_now  = blink_next[BLINK_LOG2];

  // Free-running count of scan-slot wraps; its top bit is the blink phase.
  always_ff @(posedge clk_i) begin
    if (rst_i) blink_cnt <= '0;
    else       blink_cnt <= blink_next;
  end
`else
  // Blink not built: an invalid display is a steady dash.
  assign blank_now = 1'b0 & (BLINK_LOG2 > 0);
`endif

  // Capture, display register, prescaler/scan and registered digit mux.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc       <= '0;
      idx         <= '0;
      valid_q     <= 1'b0;
      disp_bcd    <= '0;
      disp_valid  <= 1'b0;
      seg_o       <= SEG_DASH;
      digit_sel_o <= ~DIGITS'(1);
    end else begin
      presc       <= slot_wrap ? '0 : presc + PRE_W'(1);
      idx         <= idx_next;
      if (load_ok) valid_q <= entry.valid;
      disp_bcd    <= bcd_next;
      disp_valid  <= valid_next;
      digit_sel_o <= ~(DIGITS'(1) << idx_next);
      if (valid_next) seg_o <= seg_digit(digit_next);
      else            seg_o <= blank_now ? SEG_BLANK : SEG_DASH;
    end
  end

endmodule

// File: tb/tb_opcode_display_scanner.sv
// Self-checking bench for opcode_display_scanner: a timeline model of the
// display (accept edge, commit edge, slot number) checked every cycle against
// a 2-digit and a 1-digit instance, plus literal expectations for key cases.
module tb_opcode_display_scanner;

  localparam int OPCODE_W   = 4;
  localparam int SCAN_DIV   = 4;
  localparam int BLINK_LOG2 = 1;
  localparam int LAT        = 8;

  localparam logic [6:0] L_DASH  = 7'b0111111;
  localparam logic [6:0] L_BLANK = 7'b1111111;
  localparam logic [6:0] PAT [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                       7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic                clk = 1'b0;
  logic                rst_i = 1'b1;
  logic                load_i = 1'b0;
  logic [OPCODE_W-1:0] opcode_i = '0;
  logic                busy, busy1;
  logic [6:0]          seg, seg1;
  logic [1:0]          sel;
  logic [0:0]          sel1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  opcode_display_scanner #(.OPCODE_W(OPCODE_W), .DIGITS(2), .SCAN_DIV(SCAN_DIV),
                           .BLINK_LOG2(BLINK_LOG2)) dut (
    .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .load_i(load_i),
    .busy_o(busy), .seg_o(seg), .digit_sel_o(sel)
  );

  opcode_display_scanner #(.OPCODE_W(OPCODE_W), .DIGITS(1), .SCAN_DIV(SCAN_DIV),
                           .BLINK_LOG2(BLINK_LOG2)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .load_i(load_i),
    .busy_o(busy1), .seg_o(seg1), .digit_sel_o(sel1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Label table from the opcode list; -1 means invalid.
  function automatic int tb_label(input int op);
    if (op < 8)   return op + 1;
    if (op == 9)  return 9;
    if (op == 14) return 10;
    return -1;
  endfunction

  // ---------------- timeline model ----------------
  int edge_n      = 0;
  int rst_edge    = 0;
  int accept_edge = -1000;
  int pend_label  = -1;
  int disp_label  = -1;
  bit model_ok    = 1'b0;

  always @(posedge clk) begin
    edge_n++;
    if (rst_i) begin
      rst_edge    = edge_n;
      accept_edge = -1000;
      disp_label  = -1;
      model_ok    = 1'b1;
    end else begin
      if (edge_n == accept_edge + LAT + 1) disp_label = pend_label;
      if (load_i && !((edge_n - 1 - accept_edge) >= 0 && (edge_n - 1 - accept_edge) < LAT)) begin
        accept_edge = edge_n;
        pend_label  = tb_label(int'(opcode_i));
      end
    end
  end

  function automatic logic [6:0] exp_seg(input int ndig, input int idx, input int slot);
    int pw;
    bit blank;
    pw = (ndig == 1) ? 10 : 100;
    blank = 1'b0;
`ifdef OPCODE_DISPLAY_BLINK_EN
    blank = ((slot >> BLINK_LOG2) & 1) != 0;
`endif
    if (disp_label >= 0 && disp_label < pw)
      return PAT[((idx == 0) ? disp_label : disp_label / 10) % 10];
    return blank ? L_BLANK : L_DASH;
  endfunction

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin : cmp
    int slot, idx;
    logic [1:0] esel;
    if (model_ok) begin
      slot = (edge_n - rst_edge) / SCAN_DIV;
      idx  = slot % 2;
      esel = ~(2'b01 << idx);
      check("model busy", busy, ((edge_n - accept_edge) >= 0 && (edge_n - accept_edge) < LAT));
      check("model busy1", busy1, ((edge_n - accept_edge) >= 0 && (edge_n - accept_edge) < LAT));
      check("model sel", sel, esel);
      check("model seg", seg, exp_seg(2, idx, slot));
      check("model sel1", sel1, 1'b0);
      check("model seg1", seg1, exp_seg(1, 0, slot));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_dash(input string name, input logic [6:0] s);
`ifdef OPCODE_DISPLAY_BLINK_EN
    check(name, (s == L_DASH || s == L_BLANK), 1);
`else
    check(name, s, L_DASH);
`endif
  endtask

  task automatic wait_digit(input int d, output logic [6:0] s, output bit ok);
    ok = 1'b0;
    s  = 'x;
    for (int i = 0; i < 3 * SCAN_DIV; i++) begin
      if (sel == ~(2'b01 << d)) begin
        ok = 1'b1;
        s  = seg;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check({name, " idle timeout"}, busy, 0);
  endtask

  // Load op from idle, count busy cycles, then read both digits after commit.
  task automatic run_op(input string name, input int op, input logic [6:0] e0,
                        input logic [6:0] e1, input logic [6:0] e_one, input bit inv);
    int n;
    logic [6:0] s;
    bit ok;
    load_i = 1'b1;
    opcode_i = OPCODE_W'(op);
    @(negedge clk);
    load_i = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check({name, " busy cycles"}, n, LAT);
    @(negedge clk);
    wait_digit(0, s, ok);
    check({name, " d0 found"}, ok, 1);
    if (inv) check_dash({name, " d0"}, s); else check({name, " d0"}, s, e0);
    wait_digit(1, s, ok);
    check({name, " d1 found"}, ok, 1);
    if (inv) check_dash({name, " d1"}, s); else check({name, " d1"}, s, e1);
    if (e_one == L_DASH) check_dash({name, " 1-digit"}, seg1);
    else                 check({name, " 1-digit"}, seg1, e_one);
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and idle scan
    @(negedge clk);
    rst_i = 1'b0;
    check("reset busy", busy, 0);
    check("reset seg", seg, L_DASH);
    check("reset sel", sel, 2'b10);
    repeat (SCAN_DIV) @(negedge clk);
    check("slot1 sel", sel, 2'b01);
    check("slot1 seg", seg, L_DASH);
    check("slot1 busy", busy, 0);
    repeat (SCAN_DIV) @(negedge clk);
    check("slot2 sel", sel, 2'b10);

    // Directed conversions
    run_op("op14", 14, 7'b1000000, 7'b1111001, L_DASH, 1'b0);
    run_op("op0",  0,  7'b1111001, 7'b1000000, 7'b1111001, 1'b0);
    run_op("op9",  9,  7'b0010000, 7'b1000000, 7'b0010000, 1'b0);
    run_op("op8",  8,  L_DASH, L_DASH, L_DASH, 1'b1);
    run_op("op7",  7,  7'b0000000, 7'b1000000, 7'b0000000, 1'b0);

    // Load while busy is ignored; reload on the first idle edge is accepted
    load_i = 1'b1;
    opcode_i = 4'd14;
    @(negedge clk);
    load_i = 1'b0;
    repeat (2) @(negedge clk);
    load_i = 1'b1;
    opcode_i = 4'd3;
    @(negedge clk);
    load_i = 1'b0;
    wait_idle("ignore");
    load_i = 1'b1;
    opcode_i = 4'd2;
    @(negedge clk);
    load_i = 1'b0;
    check("reload accepted", busy, 1);
    check("ignored load shows 10", seg, (sel == 2'b10) ? 7'b1000000 : 7'b1111001);
    wait_idle("reload");
    begin : rl
      logic [6:0] s;
      bit ok;
      @(negedge clk);
      wait_digit(0, s, ok);
      check("op2 d0", s, 7'b0110000);
      wait_digit(1, s, ok);
      check("op2 d1", s, 7'b1000000);
    end

    // Reset at N+4 aborts the conversion
    load_i = 1'b1;
    opcode_i = 4'd9;
    @(negedge clk);
    load_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("abort busy", busy, 0);
    check("abort sel", sel, 2'b10);
    check("abort seg", seg, L_DASH);
    repeat (12) @(negedge clk);
    check("abort stays idle", busy, 0);

    // Randomized loads, opcodes and occasional resets
    for (int i = 0; i < 600; i++) begin
      load_i   = ($urandom_range(0, 3) == 0);
      opcode_i = OPCODE_W'($urandom);
      rst_i    = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end
    load_i = 1'b0;
    rst_i  = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
